// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between EX and the iterative divider
interface div_seq_if #(parameter int WIDTH = 32);
  logic                 start_i;
  logic                 annul_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stallreq_o;
  modport master (output start_i, annul_i, signed_i, dividend_i, divisor_i,
                  input  result_o, ready_o, stallreq_o);
  modport slave  (input  start_i, annul_i, signed_i, dividend_i, divisor_i,
                  output result_o, ready_o, stallreq_o);
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with pipeline stall
module div_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d, dvs_q, dvs_d, rem_q, rem_d, orig_q, orig_d;
  logic               sq_q, sq_d, sr_q, sr_d, ready_q, ready_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               go;
  assign go    = bus.start_i & ~bus.annul_i;
  assign a_mag = (bus.signed_i & bus.dividend_i[WIDTH-1]) ? -bus.dividend_i : bus.dividend_i;
  assign b_mag = (bus.signed_i & bus.divisor_i[WIDTH-1]) ? -bus.divisor_i : bus.divisor_i;
  // one extra bit so divisors above 2^(WIDTH-1) still restore correctly
  assign trial = {rem_q, dq_q[WIDTH-1]} - {1'b0, dvs_q};
  assign bus.result_o   = res_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = go & (state_q != END);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    orig_d  = orig_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    ready_d = ready_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = (bus.divisor_i == '0) ? DIVZERO : ON;
        cnt_d   = '0;
        dq_d    = a_mag;
        dvs_d   = b_mag;
        rem_d   = '0;
        orig_d  = bus.dividend_i;
        sq_d    = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
        sr_d    = bus.signed_i & bus.dividend_i[WIDTH-1];
      end
      DIVZERO: begin
        state_d = !go ? IDLE : (cnt_q == ONE) ? END : DIVZERO;
        cnt_d   = cnt_q + ONE;
        ready_d = go && cnt_q == ONE;
        res_d   = (go && cnt_q == ONE) ? {orig_q, {WIDTH{1'b1}}} : '0;
      end
      ON: begin
        state_d = !go ? IDLE : (cnt_q == LAST) ? END : ON;
        cnt_d   = cnt_q + ONE;
        rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], dq_q[WIDTH-1]} : trial[WIDTH-1:0];
        dq_d    = {dq_q[WIDTH-2:0], ~trial[WIDTH]};
        ready_d = go && cnt_q == LAST;
        res_d   = (go && cnt_q == LAST) ? {sr_q ? -rem_q : rem_q, sq_q ? -dq_q : dq_q} : '0;
      end
      END: if (!go) begin
        state_d = IDLE;
        ready_d = 1'b0;
        res_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      orig_q  <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      orig_q  <= orig_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with hand-computed results
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  div_seq_if #(.WIDTH(32)) bus ();
  div_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = s;
    bus.dividend_i = a;
    bus.divisor_i  = b;
  endtask
  task automatic wait_ready(output int n, output logic stall_ok);
    stall_ok = 1'b1;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.ready_o) break;
      n++;
      if (!bus.stallreq_o) stall_ok = 1'b0;
      if (n == 1) begin
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        bus.signed_i   = ~bus.signed_i;
      end
    end
  endtask
  task automatic watch_quiet(input string tag, input int cycles);
    logic rose = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.ready_o) rose = 1'b1;
    end
    check(tag, rose, 0);
  endtask
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    logic ok;
    launch(s, a, b);
    wait_ready(n, ok);
    check({tag, " lat"}, n, lat);
    check({tag, " res"}, bus.result_o, exp);
    check({tag, " stall"}, ok, 1);
    check({tag, " stall@rdy"}, bus.stallreq_o, 0);
    @(negedge clk);
    check({tag, " hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, exp[62:0]});
    bus.start_i = 1'b0;
    @(negedge clk);
    check({tag, " drop"}, {bus.ready_o, bus.result_o[62:0]}, 64'd0);
  endtask
  initial begin
    int n;
    logic ok;
    bus.start_i = 0; bus.annul_i = 0; bus.signed_i = 0; bus.dividend_i = 0; bus.divisor_i = 0;
    #12;
    check("reset", {bus.ready_o, bus.stallreq_o, bus.result_o[61:0]}, 64'd0);
    @(negedge clk) rst = 1'b1;
    run_div("u100/7",   0, 32'd100,      32'd7,        {32'h2,        32'hE},        33);
    run_div("s-7/2",    1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("s7/-2",    1, 32'h7,        32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD}, 33);
    run_div("s-100/-7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'hE},        33);
    run_div("u-7/2",    0, 32'hFFFFFFF9, 32'h2,        {32'h1,        32'h7FFFFFFC}, 33);
    run_div("ubigdvs",  0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'h1},        33);
    run_div("s5/0",     1, 32'h5,        32'h0,        {32'h5,        32'hFFFFFFFF}, 2);
    run_div("u5/0",     0, 32'h5,        32'h0,        {32'h5,        32'hFFFFFFFF}, 2);
    run_div("s-8/0",    1, 32'hFFFFFFF8, 32'h0,        {32'hFFFFFFF8, 32'hFFFFFFFF}, 2);
    run_div("sovf",     1, 32'h80000000, 32'hFFFFFFFF, {32'h0,        32'h80000000}, 33);
    run_div("uovf",     0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0},        33);
    launch(0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    check("annul pre stall", bus.stallreq_o, 1);
    bus.annul_i = 1'b1;
    #1 check("annul stall", bus.stallreq_o, 0);
    @(negedge clk);
    check("annul ready", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    watch_quiet("annul quiet", 40);
    run_div("uFFFF/10", 0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);
    launch(0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b0;
    watch_quiet("drop quiet", 40);
    run_div("u100/7b", 0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    launch(0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("rst on", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    watch_quiet("rst idle", 5);
    launch(0, 32'd100, 32'd7);
    wait_ready(n, ok);
    check("pre-rst lat", n, 33);
    check("pre-rst res", bus.result_o, {32'h2, 32'hE});
    #2 rst = 1'b0;
    #1 check("rst end", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    watch_quiet("rst end idle", 5);
    run_div("post-rst", 1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
